// File: rtl/truth_table_sweeper_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_if
// Control and result bundle between a host and the truth-table sweeper.
//   start          host -> sweeper  begin a sweep (sampled only when idle)
//   expected[15:0] host -> sweeper  expected truth table, bit i = vector i
//   busy           sweeper -> host  sweep in progress
//   done           sweeper -> host  one-cycle pulse at end of sweep
//   pass           sweeper -> host  no mismatches (valid from done on)
//   truth_table    sweeper -> host  measured S values, bit i = vector i
//   mismatch_count sweeper -> host  number of failing vectors (0..16)
//   fail_valid     sweeper -> host  at least one mismatch this sweep
//   first_fail     sweeper -> host  lowest failing vector index
// Modports: master = host side, slave = sweeper side.
// ---------------------------------------------------------------------------
interface truth_table_sweeper_if;
  logic        start;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic        fail_valid;
  logic [3:0]  first_fail;

  modport master (
    output start, expected,
    input  busy, done, pass, truth_table, mismatch_count, fail_valid, first_fail
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, truth_table, mismatch_count, fail_valid, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Drives a 4-input combinational block through all 16 input vectors, holds
// each vector for SETTLE_CYCLES cycles, samples the block's output S, builds
// the measured truth table and compares it against an expected table.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      control/result bundle (truth_table_sweeper_if.slave)
//   dut_in   vector driven to the block under test, {a,b,c,d}, a = MSB
//   dut_out  output S of the block under test
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//
// Optional build macro:
//   STOP_ON_FAIL_EN  when defined, the first mismatching vector ends the
//                    sweep immediately; otherwise all 16 vectors always run.
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus,
  output logic [3:0]            dut_in,
  input  logic                  dut_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Last settle count value before moving to SAMPLE
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  index;
  logic [3:0]  settle_cnt;
  logic [15:0] expected_q;
  logic [15:0] truth_table_q;
  logic [4:0]  mismatch_q;
  logic        fail_valid_q;
  logic [3:0]  first_fail_q;
  logic        pass_q;

  logic        miss;
  logic [4:0]  mismatch_next;
  logic        sweep_end;

  // Compare the sampled output against the latched expectation; the updated
  // count is needed in the same cycle so pass is valid while done is high.
  assign miss          = (dut_out != expected_q[index]);
  assign mismatch_next = mismatch_q + {4'b0000, miss};

`ifdef STOP_ON_FAIL_EN
  assign sweep_end = (index == 4'd15) || miss;
`else
  assign sweep_end = (index == 4'd15);
`endif

  // Sweep sequencer: accept start, walk vectors, sample, report
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      index         <= 4'd0;
      settle_cnt    <= 4'd0;
      expected_q    <= 16'd0;
      truth_table_q <= 16'd0;
      mismatch_q    <= 5'd0;
      fail_valid_q  <= 1'b0;
      first_fail_q  <= 4'd0;
      pass_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            expected_q    <= bus.expected;
            truth_table_q <= 16'd0;
            mismatch_q    <= 5'd0;
            fail_valid_q  <= 1'b0;
            first_fail_q  <= 4'd0;
            pass_q        <= 1'b0;
            index         <= 4'd0;
            settle_cnt    <= 4'd0;
            state         <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          truth_table_q[index] <= dut_out;
          mismatch_q           <= mismatch_next;
          if (miss && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            first_fail_q <= index;
          end
          if (sweep_end) begin
            pass_q <= (mismatch_next == 5'd0);
            state  <= ST_FINISH;
          end else begin
            index      <= index + 4'd1;
            settle_cnt <= 4'd0;
            state      <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // index is not advanced past the final vector, so dut_in keeps it in IDLE
  assign dut_in             = index;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = (state == ST_FINISH);
  assign bus.pass           = pass_q;
  assign bus.truth_table    = truth_table_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail     = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed self-checking bench for truth_table_sweeper with SETTLE_CYCLES=2.
// The block under test is modelled as S = ~c & (a | b&d) (table 16'h3320),
// or tied low / tied high, selected by dut_mode.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic [3:0] dut_in;
  logic       dut_out;
  logic [1:0] dut_mode;
  logic       model_s;

  int errors = 0;
  int checks = 0;

  truth_table_sweeper_if bus ();

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .dut_in  (dut_in),
    .dut_out (dut_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block under test: dut_in = {a,b,c,d}
  assign model_s = ~dut_in[1] & (dut_in[3] | (dut_in[2] & dut_in[0]));
  assign dut_out = (dut_mode == 2'd0) ? model_s :
                   (dut_mode == 2'd1) ? 1'b0 : 1'b1;

`ifdef STOP_ON_FAIL_EN
  localparam int          ONE_MISS_DONE = 3;
  localparam logic [15:0] ONE_MISS_TT   = 16'h0000;
  localparam logic [3:0]  ONE_MISS_IN   = 4'd0;
  localparam int          LOW_DONE      = 18;
  localparam logic [4:0]  LOW_MM        = 5'd1;
  localparam int          HIGH_DONE     = 3;
  localparam logic [15:0] HIGH_TT       = 16'h0001;
  localparam logic [4:0]  HIGH_MM       = 5'd1;
`else
  localparam int          ONE_MISS_DONE = 48;
  localparam logic [15:0] ONE_MISS_TT   = 16'h3320;
  localparam logic [3:0]  ONE_MISS_IN   = 4'd15;
  localparam int          LOW_DONE      = 48;
  localparam logic [4:0]  LOW_MM        = 5'd5;
  localparam int          HIGH_DONE     = 48;
  localparam logic [15:0] HIGH_TT       = 16'hFFFF;
  localparam logic [4:0]  HIGH_MM       = 5'd16;
`endif

  // Start a sweep from IDLE and watch max_edges edges after acceptance.
  // Extra start pulses are driven before edges extra_a/extra_b, and the
  // expected input is scrambled once the sweep is running.
  task automatic run_sweep(input logic [15:0] exp, input int extra_a,
                           input int extra_b, input int max_edges,
                           output int first_done, output int done_cnt,
                           output logic busy_acc);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.expected = exp;
    @(posedge clk);
    #1;
    busy_acc   = bus.busy;
    first_done = -1;
    done_cnt   = 0;
    for (int n = 1; n <= max_edges; n++) begin
      @(negedge clk);
      bus.start    = (n == extra_a) || (n == extra_b);
      bus.expected = ~exp;
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, want 0000", {bus.busy, bus.done, bus.pass, bus.fail_valid});
    end
    checks++;
    if (bus.truth_table !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_tt: got %h, want 0000", bus.truth_table);
    end
    checks++;
    if ({bus.mismatch_count, bus.first_fail, dut_in} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: mm=%0d ff=%0d in=%0d, want 0 0 0", bus.mismatch_count, bus.first_fail, dut_in);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass_sweep();
    int fd, dc;
    logic ba;
    dut_mode = 2'd0;
    run_sweep(16'h3320, -1, -1, 55, fd, dc, ba);
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pass_busy: got %b, want 1", ba);
    end
    checks++;
    if (fd !== 48 || dc !== 1) begin
      errors++;
      $display("[TB] FAIL pass_done: edge=%0d count=%0d, want 48 1", fd, dc);
    end
    checks++;
    if (bus.truth_table !== 16'h3320) begin
      errors++;
      $display("[TB] FAIL pass_tt: got %h, want 3320", bus.truth_table);
    end
    checks++;
    if (bus.mismatch_count !== 5'd0 || bus.pass !== 1'b1 || bus.fail_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_result: mm=%0d pass=%b fv=%b, want 0 1 0", bus.mismatch_count, bus.pass, bus.fail_valid);
    end
    checks++;
    if (dut_in !== 4'd15 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_idle: in=%0d busy=%b, want 15 0", dut_in, bus.busy);
    end
  endtask

  task automatic test_single_mismatch();
    int fd, dc;
    logic ba;
    dut_mode = 2'd0;
    run_sweep(16'h3321, -1, -1, 55, fd, dc, ba);
    checks++;
    if (fd !== ONE_MISS_DONE) begin
      errors++;
      $display("[TB] FAIL one_miss_done: got %0d, want %0d", fd, ONE_MISS_DONE);
    end
    checks++;
    if (bus.mismatch_count !== 5'd1 || bus.fail_valid !== 1'b1 || bus.first_fail !== 4'd0 || bus.pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL one_miss_result: mm=%0d fv=%b ff=%0d pass=%b, want 1 1 0 0", bus.mismatch_count, bus.fail_valid, bus.first_fail, bus.pass);
    end
    checks++;
    if (bus.truth_table !== ONE_MISS_TT || dut_in !== ONE_MISS_IN) begin
      errors++;
      $display("[TB] FAIL one_miss_tt: tt=%h in=%0d, want %h %0d", bus.truth_table, dut_in, ONE_MISS_TT, ONE_MISS_IN);
    end
  endtask

  task automatic test_stuck_low();
    int fd, dc;
    logic ba;
    dut_mode = 2'd1;
    run_sweep(16'h3320, -1, -1, 55, fd, dc, ba);
    checks++;
    if (fd !== LOW_DONE || dc !== 1) begin
      errors++;
      $display("[TB] FAIL low_done: edge=%0d count=%0d, want %0d 1", fd, dc, LOW_DONE);
    end
    checks++;
    if (bus.truth_table !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL low_tt: got %h, want 0000", bus.truth_table);
    end
    checks++;
    if (bus.mismatch_count !== LOW_MM || bus.first_fail !== 4'd5 || bus.pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL low_result: mm=%0d ff=%0d pass=%b, want %0d 5 0", bus.mismatch_count, bus.first_fail, bus.pass, LOW_MM);
    end
  endtask

  task automatic test_stuck_high();
    int fd, dc;
    logic ba;
    dut_mode = 2'd2;
    run_sweep(16'h0000, -1, -1, 55, fd, dc, ba);
    checks++;
    if (fd !== HIGH_DONE) begin
      errors++;
      $display("[TB] FAIL high_done: got %0d, want %0d", fd, HIGH_DONE);
    end
    checks++;
    if (bus.truth_table !== HIGH_TT) begin
      errors++;
      $display("[TB] FAIL high_tt: got %h, want %h", bus.truth_table, HIGH_TT);
    end
    checks++;
    if (bus.mismatch_count !== HIGH_MM || bus.first_fail !== 4'd0 || bus.fail_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL high_result: mm=%0d ff=%0d fv=%b, want %0d 0 1", bus.mismatch_count, bus.first_fail, bus.fail_valid, HIGH_MM);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int fd, dc, late_done;
    logic ba;
    dut_mode = 2'd0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.expected = 16'h3320;
    @(posedge clk);
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
    end
    #1;
    checks++;
    if (dut_in !== 4'd7 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_index: in=%0d busy=%b, want 7 1", dut_in, bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid, bus.truth_table, bus.mismatch_count, bus.first_fail, dut_in} !== 33'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b tt=%h mm=%0d in=%0d, want all 0", bus.busy, bus.done, bus.truth_table, bus.mismatch_count, dut_in);
    end
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("[TB] FAIL mid_no_done: got %0d pulses, want 0", late_done);
    end
    run_sweep(16'h3320, -1, -1, 55, fd, dc, ba);
    checks++;
    if (fd !== 48 || bus.truth_table !== 16'h3320 || bus.pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_restart: edge=%0d tt=%h pass=%b, want 48 3320 1", fd, bus.truth_table, bus.pass);
    end
  endtask

  task automatic test_ignored_start();
    int fd, dc;
    logic ba;
    dut_mode = 2'd0;
    run_sweep(16'h3320, 10, 30, 70, fd, dc, ba);
    checks++;
    if (fd !== 48 || dc !== 1) begin
      errors++;
      $display("[TB] FAIL ignored_start: edge=%0d count=%0d, want 48 1", fd, dc);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, dc;
    logic busy49, busy50;
    dut_mode = 2'd0;
    d1 = -1;
    d2 = -1;
    dc = 0;
    busy49 = 1'bx;
    busy50 = 1'bx;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.expected = 16'h3320;
    @(posedge clk);
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk);
      bus.start = (n <= 60);
      @(posedge clk);
      #1;
      if (n == 49) busy49 = bus.busy;
      if (n == 50) busy50 = bus.busy;
      if (bus.done) begin
        dc++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (d1 !== 48 || d2 !== 98 || dc !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_done: d1=%0d d2=%0d count=%0d, want 48 98 2", d1, d2, dc);
    end
    checks++;
    if (busy49 !== 1'b0 || busy50 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: busy49=%b busy50=%b, want 0 1", busy49, busy50);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.expected = 16'h0000;
    dut_mode     = 2'd0;
    test_reset();
    test_pass_sweep();
    test_single_mismatch();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid_sweep();
    test_ignored_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Stimulus-and-capture engine for the lab's 4-input combinational logic blocks. It drives the DUT inputs a,b,c,d through all 16 combinations and waits a programmable settle time at each one. It then samples the DUT output S, builds the measured truth table and compares it bit-by-bit against an expected table. This is the driving end of the DUT's a/b/c/d -> S interface, and it lets board or bench checks run unattended.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before S is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset
start  input  1  begin a sweep; sampled only in IDLE
expected  input  16  expected truth table; bit i = expected S for vector i; latched on start
dut_in  output  4  vector driven to DUT, {a,b,c,d}, a = MSB
dut_out  input  1  DUT output S
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at end of sweep
pass  output  1  mismatch_count==0; valid from done until next start
truth_table  output  16  measured S values; bit i = vector i
mismatch_count  output  5  number of vectors where S != expected (0..16)
fail_valid  output  1  at least one mismatch seen in this sweep
first_fail  output  4  lowest failing vector index; meaningful only when fail_valid=1

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, truth_table=0, mismatch_count=0, fail_valid=0, first_fail=0.
- Reset mid-sweep aborts immediately to these values. No done pulse is produced.
- States:
  - IDLE: busy=0. If start=1, latch expected, clear truth_table, mismatch_count, fail_valid, first_fail and pass, set index=0 and settle_cnt=0, then go to DRIVE.
  - DRIVE: dut_in=index; settle_cnt increments each cycle; when settle_cnt==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: dut_in held. Write truth_table[index] <= dut_out. If dut_out != expected_latched[index], increment mismatch_count. On the first mismatch of the sweep, also set fail_valid=1 and first_fail=index. If index==15, go to FINISH. Otherwise index++, settle_cnt=0, go to DRIVE.
  - FINISH: done=1 for exactly this cycle; pass=(mismatch_count==0); go to IDLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done is high in the cycle that begins 16*(SETTLE_CYCLES+1) edges after the edge that accepted start (48 edges for the default).
  - busy is high from the cycle after acceptance through the FINISH cycle inclusive.
- dut_in keeps the last driven vector (15) in IDLE after a sweep; reset returns it to 0.
- start while busy=1 is ignored. It does not queue.
- Changes on expected during a sweep have no effect.
- start held high continuously causes back-to-back sweeps, with one IDLE cycle between FINISH and the next DRIVE.
- mismatch_count is 5 bits, so 16 mismatches is representable with no wrap.
- truth_table, counts, pass and first_fail hold their values in IDLE until the next accepted start.

Optional Feature:
STOP_ON_FAIL_EN
- Defined: SAMPLE with a mismatch goes directly to FINISH regardless of index. Untested truth_table bits stay 0, mismatch_count=1, pass=0.
- Undefined: the full 16-vector sweep always runs, as described above.

Test Plan:
- DUT model S = ~c & (a | b&d), expected=16'h3320, SETTLE_CYCLES=2, start pulse -> done 48 edges after acceptance, truth_table=16'h3320, mismatch_count=0, pass=1, fail_valid=0.
- Same DUT, expected=16'h3321 -> mismatch_count=1, fail_valid=1, first_fail=0, pass=0, truth_table=16'h3320.
- dut_out tied 0, expected=16'h3320 -> truth_table=0, mismatch_count=5, first_fail=5, pass=0. With STOP_ON_FAIL_EN: mismatch_count=1, first_fail=5, done at edge 18.
- dut_out tied 1, expected=16'h0000 -> mismatch_count=16, first_fail=0, truth_table=16'hFFFF.
- rst asserted for one cycle while index=7 -> next cycle: all outputs at reset values, no done. A fresh start then completes a normal sweep.
- Extra start pulses at edges 10 and 30 of a running sweep -> ignored; exactly one done pulse, at edge 48.
